// File: rtl/riscv_pkg.sv
// Shared integer-core types: register index, x0 constant and the writeback request record.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] regidx_t;

   localparam regidx_t X0 = 5'd0;

   typedef struct packed {
      regidx_t          rd;
      logic [XLEN-1:0]  data;
   } wb_req_t;

   function automatic logic [31:0] rd_onehot(input regidx_t rd);
      logic [31:0] m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rf_writeback_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests; exposes per-slot valid bits and contents
// so the arbiter can build its pending-register mask.
module wb_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  wb_req_t               push_data,
   input  logic                  pop,
   output wb_req_t               head,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH-1:0]      entry_valid,
   output wb_req_t [DEPTH-1:0]   entries
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   wb_req_t [DEPTH-1:0]  mem;
   logic [DEPTH-1:0]     vld;
   logic                 do_push;
   logic                 do_pop;

   // A push into a full FIFO is refused even when a pop frees a slot the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
         mem    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign head        = mem[rd_ptr];
   assign entry_valid = vld;
   assign entries     = mem;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Regfile write-port arbiter: pipeline writes win, long-latency writes queue in a FIFO.
// Optional starvation monitor enabled by defining WB_STARVE_CHK_EN.
module rf_writeback_arbiter
   import riscv_pkg::*;
#(
   parameter int XLEN         = riscv_pkg::XLEN,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pipe_valid,
   input  logic [4:0]                   pipe_rd,
   input  logic [XLEN-1:0]              pipe_data,
   input  logic                         ll_valid,
   output logic                         ll_ready,
   input  logic [4:0]                   ll_rd,
   input  logic [XLEN-1:0]              ll_data,
   output logic                         rf_we,
   output logic [4:0]                   rf_waddr,
   output logic [XLEN-1:0]              rf_wdata,
   output logic [31:0]                  pending_mask,
`ifdef WB_STARVE_CHK_EN
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         starve_err
`else
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`endif
);

   if (XLEN != riscv_pkg::XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("rf_writeback_arbiter: unsupported parameter combination");
   end

   wb_req_t              head;
   wb_req_t              push_req;
   wb_req_t [DEPTH-1:0]  entries;
   logic [DEPTH-1:0]     entry_valid;
   logic                 full;
   logic                 empty;
   logic                 pipe_take;
   logic                 ll_live;
   logic                 pop;
   logic                 bypass;
   logic                 push;

   assign ll_ready  = rst_n && !full;
   assign pipe_take = pipe_valid && (pipe_rd != X0);
   assign ll_live   = ll_valid && ll_ready && (ll_rd != X0);
   assign pop       = !pipe_take && !empty;
   assign bypass    = !pipe_take && empty && ll_live;
   assign push      = ll_live && !bypass;
   assign push_req  = '{rd: ll_rd, data: ll_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_data   (push_req),
      .pop         (pop),
      .head        (head),
      .count       (fifo_count),
      .full        (full),
      .empty       (empty),
      .entry_valid (entry_valid),
      .entries     (entries)
   );

   // Only entries still in the FIFO are pending; once in the output register the regfile bypass covers them.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(entries[i].rd);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (pipe_take) begin
         rf_we    <= 1'b1;
         rf_waddr <= pipe_rd;
         rf_wdata <= pipe_data;
      end else if (pop) begin
         rf_we    <= 1'b1;
         rf_waddr <= head.rd;
         rf_wdata <= head.data;
      end else if (bypass) begin
         rf_we    <= 1'b1;
         rf_waddr <= ll_rd;
         rf_wdata <= ll_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

`ifdef WB_STARVE_CHK_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] wait_cnt;

   // Outside empty/pop the slot went to the pipeline while a head waited.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         starve_err <= 1'b0;
      end else if (empty || pop) begin
         wait_cnt   <= '0;
      end else begin
         if (int'(wait_cnt) < STARVE_LIMIT) wait_cnt <= wait_cnt + SW'(1);
         if (int'(wait_cnt) + 1 >= STARVE_LIMIT && !starve_err) begin
            starve_err <= 1'b1;
`ifdef SIM
            $display("WB: starve x%0d", head.rd);
`endif
         end
      end
   end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: a queue model predicts every write, occupancy and mask.
module tb_rf_writeback_arbiter;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      int          count;
      logic [31:0] mask;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        pv;
      logic [4:0]  prd;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
   } stim_t;

   logic        clk;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;
   logic [1:0]  fifo_count;
`ifdef WB_STARVE_CHK_EN
   logic        starve_err;
`endif

   exp_t        sb[$];
   ent_t        mq[$];
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        exp_ready;
   int          tests;
   int          fails;

   rf_writeback_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_valid   (pipe_valid),
      .pipe_rd      (pipe_rd),
      .pipe_data    (pipe_data),
      .ll_valid     (ll_valid),
      .ll_ready     (ll_ready),
      .ll_rd        (ll_rd),
      .ll_data      (ll_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .pending_mask (pending_mask),
`ifdef WB_STARVE_CHK_EN
      .fifo_count   (fifo_count),
      .starve_err   (starve_err)
`else
      .fifo_count   (fifo_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs and predicts the registered result of the next edge.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      ent_t h;
      ent_t n;
      bit   acc;
      bit   byp;
      pipe_valid = s.pv;
      pipe_rd    = s.prd;
      pipe_data  = s.pd;
      ll_valid   = s.lv;
      ll_rd      = s.lrd;
      ll_data    = s.ld;
      exp_ready  = (mq.size() < 2);
      acc        = s.lv && exp_ready && (s.lrd != 5'd0);
      byp        = 1'b0;
      e.we       = 1'b1;
      if (s.pv && s.prd != 5'd0) begin
         m_addr = s.prd;
         m_data = s.pd;
      end else if (mq.size() > 0) begin
         h      = mq.pop_front();
         m_addr = h.rd;
         m_data = h.data;
      end else if (acc) begin
         m_addr = s.lrd;
         m_data = s.ld;
         byp    = 1'b1;
      end else begin
         e.we   = 1'b0;
      end
      if (acc && !byp) begin
         n.rd   = s.lrd;
         n.data = s.ld;
         mq.push_back(n);
      end
      e.addr  = m_addr;
      e.data  = m_data;
      e.count = mq.size();
      e.mask  = '0;
      foreach (mq[i]) e.mask[mq[i].rd] = 1'b1;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      tests++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || ll_ready !== 1'b0 || fifo_count !== 2'd0 || pending_mask !== 32'd0) begin
         fails++;
         $display("[TB] FAIL reset_held: we=%b addr=%0d data=%h ready=%b cnt=%0d mask=%h, want all zero", rf_we, rf_waddr, rf_wdata, ll_ready, fifo_count, pending_mask);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      tests++;
      if (ll_ready !== 1'b1 || rf_we !== 1'b0 || fifo_count !== 2'd0 || pending_mask !== 32'd0) begin
         fails++;
         $display("[TB] FAIL reset_release: ready=%b we=%b cnt=%0d mask=%h, want ready=1 we=0 cnt=0 mask=0", ll_ready, rf_we, fifo_count, pending_mask);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_pipe_write();
      stim_t st[$];
      exp_t  e;
      st.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0});
      st.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0});
      foreach (st[k]) begin
         applyStimulus(st[k]);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL pipe_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin fails++; $display("[TB] FAIL pipe_write[%0d]: got we=%b x%0d=%h want we=%b x%0d=%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
         tests++;
         if (fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin fails++; $display("[TB] FAIL pipe_state[%0d]: got cnt=%0d mask=%h want cnt=%0d mask=%h", k, fifo_count, pending_mask, e.count, e.mask); end
      end
   endtask

   task automatic test_bypass();
      stim_t st[$];
      exp_t  e;
      st.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11});
      st.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0});
      foreach (st[k]) begin
         applyStimulus(st[k]);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL bypass_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin fails++; $display("[TB] FAIL bypass_write[%0d]: got we=%b x%0d=%h want we=%b x%0d=%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
         tests++;
         if (fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin fails++; $display("[TB] FAIL bypass_state[%0d]: got cnt=%0d mask=%h want cnt=%0d mask=%h", k, fifo_count, pending_mask, e.count, e.mask); end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      exp_t  e;
      st.push_back('{1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd8,  32'hA8});
      st.push_back('{1'b1, 5'd2, 32'h0000_0202, 1'b1, 5'd9,  32'hA9});
      st.push_back('{1'b1, 5'd3, 32'h0000_0303, 1'b1, 5'd10, 32'hAA});
      st.push_back('{1'b1, 5'd4, 32'h0000_0404, 1'b1, 5'd10, 32'hAA});
      for (int i = 0; i < 3; i++) st.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0});
      foreach (st[k]) begin
         applyStimulus(st[k]);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin fails++; $display("[TB] FAIL b2b_write[%0d]: got we=%b x%0d=%h want we=%b x%0d=%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
         tests++;
         if (fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin fails++; $display("[TB] FAIL b2b_state[%0d]: got cnt=%0d mask=%h want cnt=%0d mask=%h", k, fifo_count, pending_mask, e.count, e.mask); end
      end
   endtask

   task automatic test_x0();
      stim_t st[$];
      exp_t  e;
      st.push_back('{1'b1, 5'd0, 32'hCAFE_0000, 1'b1, 5'd0, 32'hCAFE_0001});
      st.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0});
      foreach (st[k]) begin
         applyStimulus(st[k]);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL x0_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin fails++; $display("[TB] FAIL x0_write[%0d]: got we=%b x%0d=%h want we=%b x%0d=%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
         tests++;
         if (fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin fails++; $display("[TB] FAIL x0_state[%0d]: got cnt=%0d mask=%h want cnt=%0d mask=%h", k, fifo_count, pending_mask, e.count, e.mask); end
      end
   endtask

   task automatic test_random();
      stim_t s;
      exp_t  e;
      for (int k = 0; k < 60; k++) begin
         s.pv  = ($urandom_range(0, 2) == 0);
         s.prd = 5'($urandom_range(0, 7));
         s.pd  = $urandom;
         s.lv  = ($urandom_range(0, 1) == 1);
         s.lrd = 5'($urandom_range(0, 15));
         s.ld  = $urandom;
         applyStimulus(s);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin fails++; $display("[TB] FAIL rand_write[%0d]: got we=%b x%0d=%h want we=%b x%0d=%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data); end
         tests++;
         if (fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin fails++; $display("[TB] FAIL rand_state[%0d]: got cnt=%0d mask=%h want cnt=%0d mask=%h", k, fifo_count, pending_mask, e.count, e.mask); end
      end
      s = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || fifo_count !== 2'(e.count)) begin fails++; $display("[TB] FAIL rand_drain[%0d]: got we=%b x%0d=%h cnt=%0d want we=%b x%0d=%h cnt=%0d", k, rf_we, rf_waddr, rf_wdata, fifo_count, e.we, e.addr, e.data, e.count); end
      end
   endtask

`ifdef WB_STARVE_CHK_EN
   task automatic test_starve();
      stim_t s;
      exp_t  e;
      s = '{1'b1, 5'd1, 32'h5555, 1'b1, 5'd20, 32'h2020};
      applyStimulus(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      for (int k = 1; k <= 16; k++) begin
         s = '{1'b1, 5'(k % 4 + 1), 32'(k), 1'b0, 5'd0, 32'd0};
         applyStimulus(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         if (k == 15 || k == 16) begin
            tests++;
            if (starve_err !== (k == 16)) begin fails++; $display("[TB] FAIL starve_flag[%0d]: got %b want %b", k, starve_err, (k == 16)); end
         end
      end
      s = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0};
      applyStimulus(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || starve_err !== 1'b1) begin fails++; $display("[TB] FAIL starve_drain: got we=%b x%0d err=%b want we=1 x20 err=1", rf_we, rf_waddr, starve_err); end
   endtask
`endif

   task automatic test_reset_mid();
      stim_t s;
      exp_t  e;
      s = '{1'b1, 5'd1, 32'h1111, 1'b1, 5'd12, 32'hC12};
      applyStimulus(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      s = '{1'b1, 5'd2, 32'h2222, 1'b1, 5'd13, 32'hC13};
      applyStimulus(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (fifo_count !== 2'd2 || pending_mask !== 32'h0000_3000) begin fails++; $display("[TB] FAIL rstmid_fill: got cnt=%0d mask=%h want cnt=2 mask=00003000", fifo_count, pending_mask); end
      s = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0};
      pipe_valid = 1'b0;
      ll_valid   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || ll_ready !== 1'b0 || fifo_count !== 2'd0 || pending_mask !== 32'd0) begin
         fails++;
         $display("[TB] FAIL rstmid_async: we=%b addr=%0d data=%h ready=%b cnt=%0d mask=%h, want all zero", rf_we, rf_waddr, rf_wdata, ll_ready, fifo_count, pending_mask);
      end
      mq.delete();
      sb.delete();
      m_addr = '0;
      m_data = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(s);
         tests++;
         if (ll_ready !== exp_ready) begin fails++; $display("[TB] FAIL rstmid_ready[%0d]: got %b want %b", k, ll_ready, exp_ready); end
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || fifo_count !== 2'(e.count) || pending_mask !== e.mask) begin
            fails++;
            $display("[TB] FAIL rstmid_stale[%0d]: got we=%b x%0d=%h cnt=%0d want we=%b x%0d=%h cnt=%0d", k, rf_we, rf_waddr, rf_wdata, fifo_count, e.we, e.addr, e.data, e.count);
         end
      end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      m_addr     = '0;
      m_data     = '0;
      exp_ready  = 1'b0;
      rst_n      = 1'b0;
      pipe_valid = 1'b0;
      pipe_rd    = '0;
      pipe_data  = '0;
      ll_valid   = 1'b0;
      ll_rd      = '0;
      ll_data    = '0;
      test_reset();
      test_pipe_write();
      test_bypass();
      test_back_to_back();
      test_x0();
      test_random();
`ifdef WB_STARVE_CHK_EN
      test_starve();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
